// File: rtl/pwm_dt_pkg.sv
// Shared types and constants for the complementary dead-time gate driver.
package pwm_dt_pkg;

  localparam int unsigned DT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DT_HS = 3'd1,
    ST_HS_ON = 3'd2,
    ST_DT_LS = 3'd3,
    ST_LS_ON = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  typedef struct packed {
    logic hs;
    logic ls;
    logic flt;
  } gate_t;

  localparam gate_t GATE_OFF = 3'b000;

  // Moore decode: only one gate bit can ever be set for a given state.
  function automatic gate_t decode(input state_t s);
    gate_t g;
    g = GATE_OFF;
    case (s)
      ST_HS_ON: g.hs  = 1'b1;
      ST_LS_ON: g.ls  = 1'b1;
      ST_FAULT: g.flt = 1'b1;
      default:  g     = GATE_OFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate pair from a single-ended PWM with programmable
// dead time, short-pulse swallowing and a latched fault.
module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pwm_i,
  input  logic [DT_W-1:0] dt_cycles_i,
  input  logic            enable_i,
  input  logic            fault_i,
  input  logic            fault_clr_i,
  output logic            hs_o,
  output logic            ls_o,
  output logic            fault_latched_o,
  output logic [DT_W-1:0] swallow_cnt_o
);

  state_t          state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic            from_idle, from_idle_nxt;
  logic            swallow_c;
  gate_t           gate_q;

  // Dead-time entry target: a zero dead time goes straight to the ON state.
  function automatic state_t dt_target(input logic to_hs, input logic [DT_W-1:0] dt);
    if (dt == '0) return to_hs ? ST_HS_ON : ST_LS_ON;
    return to_hs ? ST_DT_HS : ST_DT_LS;
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    from_idle_nxt = from_idle;
    swallow_c     = 1'b0;
    if (fault_i) begin
      state_nxt = ST_FAULT;
      cnt_nxt   = '0;
    end else if (state == ST_FAULT) begin
      // A latched fault ignores enable_i; only an explicit clear releases it.
      if (fault_clr_i) state_nxt = ST_IDLE;
    end else if (!enable_i) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt     = dt_target(pwm_i, dt_cycles_i);
          cnt_nxt       = dt_cycles_i;
          from_idle_nxt = 1'b1;
        end
        ST_LS_ON: if (pwm_i) begin
          state_nxt     = dt_target(1'b1, dt_cycles_i);
          cnt_nxt       = dt_cycles_i;
          from_idle_nxt = 1'b0;
        end
        ST_HS_ON: if (!pwm_i) begin
          state_nxt     = dt_target(1'b0, dt_cycles_i);
          cnt_nxt       = dt_cycles_i;
          from_idle_nxt = 1'b0;
        end
        ST_DT_HS: begin
          if (!pwm_i) begin
            if (from_idle) begin
              state_nxt = dt_target(1'b0, dt_cycles_i);
              cnt_nxt   = dt_cycles_i;
            end else begin
              state_nxt = ST_LS_ON;
              swallow_c = 1'b1;
            end
          end else if (cnt <= DT_W'(1)) begin
            state_nxt = ST_HS_ON;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        ST_DT_LS: begin
          if (pwm_i) begin
            if (from_idle) begin
              state_nxt = dt_target(1'b1, dt_cycles_i);
              cnt_nxt   = dt_cycles_i;
            end else begin
              state_nxt = ST_HS_ON;
              swallow_c = 1'b1;
            end
          end else if (cnt <= DT_W'(1)) begin
            state_nxt = ST_LS_ON;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Gate outputs are registered from the next-state decode so they track state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      from_idle <= 1'b0;
      gate_q    <= GATE_OFF;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      from_idle <= from_idle_nxt;
      gate_q    <= decode(state_nxt);
    end
  end

  assign hs_o            = gate_q.hs;
  assign ls_o            = gate_q.ls;
  assign fault_latched_o = gate_q.flt;

  sat_counter #(.W(DT_W)) u_swallow_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (swallow_c),
    .clear (1'b0),
    .q     (swallow_cnt_o)
  );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed scoreboard bench for pwm_deadtime_gen.
module tb_pwm_deadtime_gen;

  typedef struct packed {
    logic       hs;
    logic       ls;
    logic       flt;
    logic [7:0] sw;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm = 1'b0;
  logic [7:0] dt  = 8'd3;
  logic       en  = 1'b0;
  logic       flt = 1'b0;
  logic       clr = 1'b0;
  logic       hs, ls, flt_l;
  logic [7:0] sw;

  int   total = 0;
  int   bad   = 0;
  exp_t   exp_q[$];
  string  tag_q[$];
  int     sw_model = 0;

  pwm_deadtime_gen #(.DT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .pwm_i           (pwm),
    .dt_cycles_i     (dt),
    .enable_i        (en),
    .fault_i         (flt),
    .fault_clr_i     (clr),
    .hs_o            (hs),
    .ls_o            (ls),
    .fault_latched_o (flt_l),
    .swallow_cnt_o   (sw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    chk({tag, ".hs"},  8'(hs),    8'(e.hs));
    chk({tag, ".ls"},  8'(ls),    8'(e.ls));
    chk({tag, ".flt"}, 8'(flt_l), 8'(e.flt));
    chk({tag, ".sw"},  sw,        e.sw);
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic cyc(input string tag, input logic eh, input logic el, input logic ef);
    exp_t e;
    exp_t p;
    string t;
    e = '{hs: eh, ls: el, flt: ef, sw: 8'(sw_model)};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    p = exp_q.pop_front();
    t = tag_q.pop_front();
    compare_all(t, p);
  endtask

  // Gates must never be high together.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (!(hs === 1'b1 && ls === 1'b1)) else begin
        bad++;
        $error("FAIL overlap observed hs=%0b ls=%0b expected not both 1", hs, ls);
      end
    end
  end

  initial begin
    exp_t z;
    z = '0;
    // Reset state
    #12;
    compare_all("reset", z);
    @(posedge clk); #1;
    rst = 1'b0;

    // Drive into HS_ON with dt=3, then reset mid-ON
    en = 1'b1; pwm = 1'b1; dt = 8'd3;
    cyc("a_dths0", 0, 0, 0);
    cyc("a_dths1", 0, 0, 0);
    cyc("a_dths2", 0, 0, 0);
    cyc("a_hson",  1, 0, 0);
    cyc("a_hson2", 1, 0, 0);
    #2 rst = 1'b1;
    #1 compare_all("a_async_rst", z);
    @(posedge clk); #1;
    rst = 1'b0; pwm = 1'b0;
    cyc("a_r1", 0, 0, 0);
    cyc("a_r2", 0, 0, 0);
    cyc("a_r3", 0, 0, 0);
    cyc("a_r4_ls", 0, 1, 0);

    // dt=4 rising from LS_ON; dt change mid-dead-time must not matter
    dt = 8'd4; pwm = 1'b1;
    cyc("b_k", 0, 0, 0);
    dt = 8'd9;
    cyc("b_k1", 0, 0, 0);
    cyc("b_k2", 0, 0, 0);
    cyc("b_k3", 0, 0, 0);
    cyc("b_k4_hs", 1, 0, 0);
    cyc("b_hold", 1, 0, 0);
    dt = 8'd4; pwm = 1'b0;
    cyc("b_f_k", 0, 0, 0);
    cyc("b_f_k1", 0, 0, 0);
    cyc("b_f_k2", 0, 0, 0);
    cyc("b_f_k3", 0, 0, 0);
    cyc("b_f_k4_ls", 0, 1, 0);

    // dt=5, 2-cycle pulse is swallowed
    dt = 8'd5; pwm = 1'b1;
    cyc("c_k", 0, 0, 0);
    cyc("c_k1", 0, 0, 0);
    pwm = 1'b0; sw_model = 1;
    cyc("c_swallow", 0, 1, 0);
    cyc("c_hold", 0, 1, 0);

    // dt=0 square wave, period 10
    dt = 8'd0;
    for (int i = 0; i < 20; i++) begin
      pwm = ((i / 5) % 2 == 0) ? 1'b1 : 1'b0;
      cyc("d_sq", pwm, !pwm, 0);
    end

    // enable low forces IDLE; restart from IDLE retargets without swallowing
    en = 1'b0;
    cyc("e_dis", 0, 0, 0);
    en = 1'b1; pwm = 1'b0; dt = 8'd3;
    cyc("e_dtls", 0, 0, 0);
    pwm = 1'b1;
    cyc("e_retarget", 0, 0, 0);
    cyc("e_rt1", 0, 0, 0);
    cyc("e_rt2", 0, 0, 0);
    cyc("e_rt_hs", 1, 0, 0);

    // fault during DT_LS
    pwm = 1'b0;
    cyc("f_dtls", 0, 0, 0);
    flt = 1'b1;
    cyc("f_fault", 0, 0, 1);
    clr = 1'b1;
    cyc("f_clr_ignored", 0, 0, 1);
    flt = 1'b0; clr = 1'b0;
    cyc("f_held", 0, 0, 1);
    clr = 1'b1;
    cyc("f_clr_idle", 0, 0, 0);
    clr = 1'b0;
    cyc("f_re1", 0, 0, 0);
    cyc("f_re2", 0, 0, 0);
    cyc("f_re3", 0, 0, 0);
    cyc("f_re4_ls", 0, 1, 0);

    // 260 swallowed pulses saturate the counter
    dt = 8'd2;
    for (int i = 0; i < 260; i++) begin
      pwm = 1'b1;
      cyc("g_dths", 0, 0, 0);
      pwm = 1'b0;
      if (sw_model < 255) sw_model++;
      cyc("g_swallow", 0, 1, 0);
    end
    chk("g_sat", sw, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Complementary-drive stage directly downstream of the UART-controlled centered PWM generator: consumes its single-ended PWM output and produces a high-side/low-side gate pair separated by a programmable dead time. Pulses shorter than the dead time are swallowed and counted. A latched fault input forces both outputs low until it is explicitly cleared. Outputs are Moore-decoded from a registered state, so the two gates are never high together.

## Interface
- DT_W, 8, width of dead-time count and swallow counter
- clk  in  1  system clock; same domain as the PWM generator
- rst  in  1  asynchronous, active-high reset
- pwm_i  in  1  single-ended PWM from the PWM core; synchronous to clk
- dt_cycles_i  in  DT_W  dead time in clk cycles; sampled on entry to a dead-time state
- enable_i  in  1  0 forces IDLE (both gates low)
- fault_i  in  1  level fault request; highest priority
- fault_clr_i  in  1  one-cycle pulse that releases a latched fault
- hs_o  out  1  high-side gate
- ls_o  out  1  low-side gate
- fault_latched_o  out  1  high while in FAULT
- swallow_cnt_o  out  DT_W  saturating count of swallowed pulses; cleared by rst only

## Operation
- States: IDLE, DT_HS (dead time before high side), HS_ON, DT_LS (dead time before low side), LS_ON, FAULT.
- Output decode:
  - hs_o=1 only in HS_ON.
  - ls_o=1 only in LS_ON.
  - fault_latched_o=1 only in FAULT.
  - All other states drive both gates 0.
- Priority of transitions from any state: fault_i > !enable_i > normal flow.
  - fault_i=1 → FAULT.
  - else enable_i=0 → IDLE.
- Normal flow:
  - IDLE, enable_i=1: go to DT_HS if pwm_i=1, otherwise DT_LS. Load cnt=dt_cycles_i.
  - LS_ON, pwm_i=1: go to DT_HS, load cnt=dt_cycles_i.
  - HS_ON, pwm_i=0: go to DT_LS, load cnt=dt_cycles_i.
  - DT_HS/DT_LS: if cnt≤1, go to the ON state; else cnt−1.
  - dt_cycles_i=0: the dead-time state is skipped and the transition goes straight to the ON state.
- Swallow rule:
  - In DT_HS with pwm_i=0: return to LS_ON and increment swallow_cnt.
  - In DT_LS with pwm_i=1: return to HS_ON and increment swallow_cnt.
  - The swallow rule does not apply when DT_* was entered from IDLE. In that case the state is re-targeted to the other DT state with cnt reloaded.
- FAULT: held while fault_i=1. Leaves to IDLE only on a cycle with fault_clr_i=1 and fault_i=0. fault_clr_i is ignored while fault_i=1.
- swallow_cnt saturates at 2^DT_W−1; no wrap.

## Timing
- Reset values: state=IDLE, cnt=0, hs_o=0, ls_o=0, fault_latched_o=0, swallow_cnt_o=0. All outputs are low asynchronously on rst assertion, including mid-dead-time or mid-ON.
- pwm_i first sampled high at edge k while in LS_ON:
  - ls_o falls after edge k.
  - hs_o rises after edge k+dt.
  - Gap between the gates is exactly dt cycles (dt≥1).
- The falling transition is symmetric.
- dt=0: the opposite gate rises at edge k with zero gap, but the two gates are never high together.
- fault_i sampled high at edge k: both gates are 0 after edge k (one-cycle latency).
- Dead time is fixed at state entry. A change to dt_cycles_i during DT_* does not affect the running count.

## Structure
- Shared package pwm_dt_pkg holds:
  - the state encoding localparams (3-bit, one value per state);
  - the default DT_W;
  - the OFF gate pattern constant.
- Sub-module sat_counter (parameter W; ports inc, clear, q) implements the swallow counter. It is reusable for future error counters.
- Everything else lives in a single always block for state/cnt and a registered output decode.

## Test plan
- Reset mid-HS_ON with dt=3: rst high → hs_o=ls_o=0 immediately. After release, enable_i=1, pwm_i=0 → ls_o=1 after 4 edges.
- dt=4, pwm_i 0→1 at edge k from LS_ON: ls_o=0 after k, hs_o=1 after k+4; the checker asserts (hs_o & ls_o)==0 every cycle.
- dt=5, pwm_i high for 2 cycles: hs_o never rises, ls_o returns high, swallow_cnt_o increments 0→1.
- dt=0, pwm_i square wave of period 10: hs_o/ls_o complementary with one-cycle latency and no overlap.
- fault_i pulse during DT_LS: both outputs 0 next cycle, fault_latched_o=1. fault_clr_i while fault_i=1 is ignored; clr after fault_i=0 → IDLE, then normal restart with dead time.
- 260 swallowed pulses with DT_W=8: swallow_cnt_o saturates at 255.
